mult_error_monitor: RTL and testbench

Hardware error-metric accumulator that sits directly downstream of the 8-bit approximate multiplier (`CSA_Mult_8bits`). It consumes operand pairs together with the approximate product, recomputes the exact product internally, and accumulates error statistics over a fixed sample window. Software derives ER, MED, MNED and mean signed error from the accumulators, so error characterisation runs on silicon or FPGA without a simulator.

---
 rtl/mult_error_monitor.sv | 199 +++++++++++++++++++
 tb/tb_mult_error_monitor.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_error_monitor.sv
// ---------------------------------------------------------------------------
// mult_error_monitor
//
// Error-metric accumulator placed downstream of an 8x8 approximate
// multiplier. Each accepted sample carries the operands and the approximate
// product; the block recomputes the exact product and accumulates error
// statistics over a window of N_SAMPLES samples. Software derives ER, MED,
// MNED and mean signed error from the final accumulator values.
//
// Parameters
//   N_SAMPLES  samples per window (1 .. 16383)
//   CW         sample / error counter width, 2**CW > N_SAMPLES
//
// Ports
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   start       one-cycle pulse: clear accumulators and open a window
//               (honoured in IDLE and DONE only)
//   in_valid    a, b, p_apprx valid this cycle
//   in_ready    block accepts a sample this cycle
//   a, b        unsigned multiplier operands
//   p_apprx     unsigned approximate product of a*b
//   busy        window in progress (RUN or DRAIN)
//   done        window complete, accumulators final and stable
//   sample_cnt  samples fully accumulated
//   err_cnt     samples whose approximate product differs from the exact one
//   sum_ed_abs  sum of |exact - apprx|
//   sum_ed      signed sum of (exact - apprx), two's complement
//   max_ed      largest |exact - apprx| seen in the window
// ---------------------------------------------------------------------------
module mult_error_monitor #(
  parameter int N_SAMPLES = 10000,
  parameter int CW        = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        a,
  input  logic [7:0]        b,
  input  logic [15:0]       p_apprx,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     sample_cnt,
  output logic [CW-1:0]     err_cnt,
  output logic [16+CW-1:0]  sum_ed_abs,
  output logic [17+CW-1:0]  sum_ed,
  output logic [15:0]       max_ed
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [CW-1:0] N_CW     = CW'(N_SAMPLES);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_SAMPLES - 1);

  state_e          state_q;
  state_e          state_d;
  logic [CW-1:0]   acc_cnt_q;     // samples accepted in this window
  logic            accept;
  logic            clear;

  // S1 pipeline registers
  logic            s1_valid_q;
  logic [15:0]     s1_exact_q;
  logic [15:0]     s1_apprx_q;

  // S2 combinational error terms
  logic signed [16:0] diff;
  logic [15:0]        diff_abs;
  logic [17+CW-1:0]   diff_ext;

  // -------------------------------------------------------------------------
  // Handshake and control decode
  // -------------------------------------------------------------------------
  assign in_ready = (state_q == S_RUN) && (acc_cnt_q < N_CW);
  assign accept   = in_valid && in_ready;

  // start only has an effect while no window is in flight; in RUN and
  // DRAIN it is ignored so a stray pulse cannot corrupt a measurement.
  assign clear    = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done     = (state_q == S_DONE);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values of the others regardless of
  // process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: state_d gets its default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (accept && (acc_cnt_q == LAST_IDX)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // The last sample sits in S1 on the first DRAIN cycle and is folded
        // into the accumulators on the following edge; once S1 is empty the
        // accumulators are final.
        if (!s1_valid_q) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Accepted-sample counter (drives in_ready and the RUN -> DRAIN exit)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_cnt_q <= '0;
    end else if (clear) begin
      acc_cnt_q <= '0;
    end else if (accept) begin
      acc_cnt_q <= acc_cnt_q + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Stage S1: capture exact and approximate products
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
    end
  end

  // NOTE: the S1 data registers carry no reset; they are only consumed while
  // s1_valid_q is set, and that bit is reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_exact_q <= 16'(a) * 16'(b);
      s1_apprx_q <= p_apprx;
    end
  end

  // -------------------------------------------------------------------------
  // Stage S2: error terms
  // -------------------------------------------------------------------------
  // Both products are zero-extended to 17 bits so the difference covers the
  // full range -65535 .. +65535 and its magnitude always fits in 16 bits.
  always_comb begin
    diff     = $signed({1'b0, s1_exact_q}) - $signed({1'b0, s1_apprx_q});
    diff_abs = diff[16] ? 16'(-diff) : diff[15:0];
    diff_ext = {{CW{diff[16]}}, diff};
  end

  // -------------------------------------------------------------------------
  // Stage S2: accumulators
  // -------------------------------------------------------------------------
  // Widths are chosen so that N_SAMPLES worst-case terms cannot wrap:
  // CW bits of count times a 16-bit magnitude, plus a sign bit for sum_ed.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sample_cnt <= '0;
      err_cnt    <= '0;
      sum_ed_abs <= '0;
      sum_ed     <= '0;
      max_ed     <= '0;
    end else if (s1_valid_q) begin
      sample_cnt <= sample_cnt + 1'b1;
      err_cnt    <= err_cnt + CW'(diff != 17'sd0);
      sum_ed_abs <= sum_ed_abs + (16+CW)'(diff_abs);
      sum_ed     <= sum_ed + diff_ext;
      if (diff_abs > max_ed) begin
        max_ed <= diff_abs;
      end
    end
  end

endmodule

// File: tb/tb_mult_error_monitor.sv
// ---------------------------------------------------------------------------
// tb_mult_error_monitor
//
// Self-checking bench for mult_error_monitor. A small instance (8-sample
// window) is driven by directed and random windows and compared against a
// behavioural model that tracks the window phase and computes the error
// statistics with plain integer arithmetic. A second instance with the
// largest legal window is driven with the worst-case error on every sample.
// ---------------------------------------------------------------------------
module tb_mult_error_monitor;

  localparam int N  = 8;
  localparam int CW = 14;
  localparam int NB = 16383;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  // small instance
  logic              start    = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        a        = '0;
  logic [7:0]        b        = '0;
  logic [15:0]       p_apprx  = '0;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic [CW-1:0]     sample_cnt;
  logic [CW-1:0]     err_cnt;
  logic [16+CW-1:0]  sum_ed_abs;
  logic [17+CW-1:0]  sum_ed;
  logic [15:0]       max_ed;

  // large instance
  logic              big_start    = 1'b0;
  logic              big_in_valid = 1'b0;
  logic              big_in_ready;
  logic              big_busy;
  logic              big_done;
  logic [CW-1:0]     big_sample_cnt;
  logic [CW-1:0]     big_err_cnt;
  logic [16+CW-1:0]  big_sum_ed_abs;
  logic [17+CW-1:0]  big_sum_ed;
  logic [15:0]       big_max_ed;

  int checks = 0;
  int errors = 0;

  // behavioural model: window phase 0 = idle, 1 = open, 2 = finished
  int     m_phase = 0;
  int     m_acc   = 0;
  longint m_cnt, m_err, m_sum_abs, m_sum, m_max;

  always #5 clk = ~clk;

  mult_error_monitor #(.N_SAMPLES(N), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .p_apprx    (p_apprx),
    .busy       (busy),
    .done       (done),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .sum_ed_abs (sum_ed_abs),
    .sum_ed     (sum_ed),
    .max_ed     (max_ed)
  );

  mult_error_monitor #(.N_SAMPLES(NB), .CW(CW)) dut_big (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (big_start),
    .in_valid   (big_in_valid),
    .in_ready   (big_in_ready),
    .a          (8'd255),
    .b          (8'd255),
    .p_apprx    (16'd0),
    .busy       (big_busy),
    .done       (big_done),
    .sample_cnt (big_sample_cnt),
    .err_cnt    (big_err_cnt),
    .sum_ed_abs (big_sum_ed_abs),
    .sum_ed     (big_sum_ed),
    .max_ed     (big_max_ed)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_acc     = 0;
    m_cnt     = 0;
    m_err     = 0;
    m_sum_abs = 0;
    m_sum     = 0;
    m_max     = 0;
  endtask

  task automatic model_add(input int ea, input int eb, input int ep);
    int d;
    int ad;
    d  = ea * eb - ep;
    ad = (d < 0) ? -d : d;
    m_cnt++;
    if (d != 0) m_err++;
    m_sum     += d;
    m_sum_abs += ad;
    if (ad > m_max) m_max = ad;
  endtask

  // One clock cycle of stimulus; checks in_ready against the model first.
  task automatic drive(input bit v, input int ea, input int eb, input int ep,
                       input bit st);
    bit exp_rdy;
    exp_rdy  = (m_phase == 1) && (m_acc < N);
    start    = st;
    in_valid = v;
    a        = 8'(ea);
    b        = 8'(eb);
    p_apprx  = 16'(ep);
    check("in_ready", in_ready, exp_rdy);
    if (v && exp_rdy) begin
      m_acc++;
      model_add(ea, eb, ep);
    end
    if (st && m_phase != 1) begin
      model_clear();
      m_phase = 1;
    end
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    drive(1'b0, 0, 0, 0, 1'b1);
  endtask

  task automatic check_totals(input string tag);
    check({tag, ".sample_cnt"}, sample_cnt, m_cnt);
    check({tag, ".err_cnt"},    err_cnt,    m_err);
    check({tag, ".sum_ed_abs"}, sum_ed_abs, m_sum_abs);
    check({tag, ".sum_ed"},     $signed(sum_ed), m_sum);
    check({tag, ".max_ed"},     max_ed,     m_max);
  endtask

  // Called one step after the edge that accepted the last sample.
  task automatic finish_window(input string tag);
    check({tag, ".done_e0"}, done, 1'b0);
    tick();
    check({tag, ".done_e1"}, done, 1'b0);
    check({tag, ".busy_e1"}, busy, 1'b1);
    check({tag, ".cnt_e1"},  sample_cnt, N);
    tick();
    check({tag, ".done_e2"}, done, 1'b1);
    check({tag, ".busy_e2"}, busy, 1'b0);
    m_phase = 2;
    check_totals(tag);
  endtask

  function automatic int rand_apprx(input int ea, input int eb);
    int e;
    int p;
    e = ea * eb;
    case ($urandom_range(0, 3))
      0:       p = e;
      1:       p = e + int'($urandom_range(1, 300));
      2:       p = e - int'($urandom_range(1, 300));
      default: p = int'($urandom_range(0, 65535));
    endcase
    if (p < 0) p = 0;
    if (p > 65535) p = 65535;
    return p;
  endfunction

  int sa [N];
  int sb [N];
  int sp [N];

  initial begin
    model_clear();

    // ---- reset state ----
    tick();
    tick();
    check("rst.in_ready", in_ready, 1'b0);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    check_totals("rst");
    rst_n = 1'b1;
    tick();

    // ---- exact multiplier, random operands ----
    do_start();
    check("exact.busy", busy, 1'b1);
    for (int i = 0; i < N; i++) begin
      sa[i] = int'($urandom_range(0, 255));
      sb[i] = int'($urandom_range(0, 255));
    end
    drive(1'b1, sa[0], sb[0], sa[0] * sb[0], 1'b0);
    check("lat.after_s1", sample_cnt, 0);
    drive(1'b1, sa[1], sb[1], sa[1] * sb[1], 1'b0);
    check("lat.after_s2", sample_cnt, 1);
    for (int i = 2; i < N; i++) drive(1'b1, sa[i], sb[i], sa[i] * sb[i], 1'b0);
    finish_window("exact");
    check("exact.err_zero", err_cnt, 0);
    check("exact.max_zero", max_ed, 0);

    // ---- start in DONE clears; directed vectors ----
    do_start();
    check("restart.in_ready", in_ready, 1'b1);
    check_totals("restart");
    drive(1'b1, 255, 255, 65025, 1'b0);
    drive(1'b1, 10, 10, 96, 1'b0);
    drive(1'b1, 3, 5, 20, 1'b0);
    drive(1'b1, 0, 0, 0, 1'b0);
    for (int i = 4; i < N; i++) drive(1'b1, 17 * i, 3 + i, 17 * i * (3 + i), 1'b0);
    finish_window("vec");
    check("vec.err_const", err_cnt, 2);
    check("vec.abs_const", sum_ed_abs, 9);
    check("vec.sum_const", $signed(sum_ed), -1);
    check("vec.max_const", max_ed, 5);

    // ---- random errors, back to back ----
    for (int i = 0; i < N; i++) begin
      sa[i] = int'($urandom_range(0, 255));
      sb[i] = int'($urandom_range(0, 255));
      sp[i] = rand_apprx(sa[i], sb[i]);
    end
    do_start();
    for (int i = 0; i < N; i++) drive(1'b1, sa[i], sb[i], sp[i], 1'b0);
    finish_window("b2b");

    // ---- same data with bubbles, start pulsed in RUN ----
    do_start();
    for (int i = 0; i < N; i++) begin
      drive(1'b1, sa[i], sb[i], sp[i], 1'b0);
      if (i == N - 1) break;
      drive(1'b0, 255, 255, 0, (i == 3));
    end
    check("bub.ready_low", in_ready, 1'b0);
    finish_window("bub");
    drive(1'b1, 1, 1, 0, 1'b0);
    check("done.hold_cnt", sample_cnt, N);
    check("done.hold_done", done, 1'b1);

    // ---- reset in the middle of a window ----
    do_start();
    for (int i = 0; i < 3; i++) drive(1'b1, 200, 200, 0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_phase = 0;
    model_clear();
    check("mid_rst.busy", busy, 1'b0);
    check("mid_rst.done", done, 1'b0);
    check_totals("mid_rst");
    drive(1'b1, 9, 9, 0, 1'b0);
    check("mid_rst.flush", sample_cnt, 0);
    do_start();
    for (int i = 0; i < N; i++) drive(1'b1, sa[i], sb[i], sp[i], 1'b0);
    finish_window("clean");

    // ---- worst-case error over the largest window ----
    big_start = 1'b1;
    tick();
    big_start = 1'b0;
    check("big.ready_first", big_in_ready, 1'b1);
    big_in_valid = 1'b1;
    repeat (NB) tick();
    check("big.ready_after", big_in_ready, 1'b0);
    big_in_valid = 1'b0;
    tick();
    check("big.done_e1", big_done, 1'b0);
    tick();
    check("big.done_e2", big_done, 1'b1);
    check("big.sample_cnt", big_sample_cnt, NB);
    check("big.err_cnt", big_err_cnt, NB);
    check("big.sum_ed_abs", big_sum_ed_abs, longint'(NB) * 65025);
    check("big.sum_ed", $signed(big_sum_ed), longint'(NB) * 65025);
    check("big.max_ed", big_max_ed, 65025);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
